// File: rtl/neuron_accumulator_pkg.sv
// Shared definitions for the neuron dot-product accumulator: FSM encoding and
// the rounding shift that maps the full-precision sum onto the output format.
package neuron_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Products carry 2*data_f fraction bits; the result keeps w_out-out_i of them.
  function automatic int round_shift(input int data_f, input int w_out, input int out_i);
    return 2 * data_f - (w_out - out_i);
  endfunction

endpackage

// File: rtl/round_saturate.sv
// Combinational round-half-up and saturate of a signed fixed-point value
// down to a W_OUT-bit two's complement result.
module round_saturate #(
  parameter int W_IN  = 25,
  parameter int SHIFT = 7,
  parameter int W_OUT = 8
) (
  input  logic signed [W_IN-1:0]  in_val,
  output logic        [W_OUT-1:0] out_val,
  output logic                    out_sat
);

  // One spare bit absorbs the rounding bias; a negative shift needs room to grow left.
  localparam int W_R = W_IN + 1 + ((SHIFT < 0) ? -SHIFT : 0);
  localparam logic signed [W_R-1:0] MAX_V = {{(W_R-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_R-1:0] MIN_V = ~MAX_V;

  logic signed [W_R-1:0] in_ext;
  logic signed [W_R-1:0] rounded;

  assign in_ext = W_R'(in_val);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [W_R-1:0] HALF = W_R'(1) << (SHIFT - 1);
      assign rounded = (in_ext + HALF) >>> SHIFT;
    end else begin : g_shift_left
      assign rounded = in_ext <<< (-SHIFT);
    end
  endgenerate

  always_comb begin
    out_val = rounded[W_OUT-1:0];
    out_sat = 1'b0;
    if (rounded > MAX_V) begin
      out_val = MAX_V[W_OUT-1:0];
      out_sat = 1'b1;
    end else if (rounded < MIN_V) begin
      out_val = MIN_V[W_OUT-1:0];
      out_sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Multiply-accumulate of N_TERMS activation/weight pairs with a registered
// product stage, then round/saturate into the tanh stage's input format.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int W_DATA  = 8,
  parameter int DATA_F  = 6,
  parameter int N_TERMS = 4,
  parameter int W_ACC   = 24,
  parameter int W_OUT   = 8,
  parameter int OUT_I   = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W_DATA-1:0] in_x,
  input  logic signed [W_DATA-1:0] in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [W_OUT-1:0]  out_data,
  output logic                     out_sat
);

  localparam int W_P   = 2 * W_DATA;
  localparam int SHIFT = round_shift(DATA_F, W_OUT, OUT_I);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [W_P-1:0]     prod_q, prod_d;
  logic                      prod_valid_q, prod_valid_d;
  logic signed [W_ACC-1:0]   acc_q, acc_d;
  logic        [W_OUT-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [W_P-1:0]     x_ext, w_ext;
  logic signed [W_ACC-1:0]   prod_ext, sum;
  logic        [W_OUT-1:0]   rs_data;
  logic                      rs_sat;
  logic                      in_fire, out_fire;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign x_ext    = W_P'(in_x);
  assign w_ext    = W_P'(in_w);
  assign prod_ext = prod_valid_q ? W_ACC'(prod_q) : '0;
  assign sum      = acc_q + prod_ext;

  // In DRAIN, sum already includes the final product still sitting in prod_q.
  round_saturate #(
    .W_IN (W_ACC),
    .SHIFT(SHIFT),
    .W_OUT(W_OUT)
  ) u_round_saturate (
    .in_val (sum),
    .out_val(rs_data),
    .out_sat(rs_sat)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = sum;
    prod_d       = in_fire ? (x_ext * w_ext) : prod_q;
    prod_valid_d = in_fire;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_fire) begin
          if (cnt_q == CNT_W'(N_TERMS - 1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        out_data_d = rs_data;
        out_sat_d  = rs_sat;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          acc_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_ACCUM;
      cnt_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: fixed vectors, hold/reset
// sequences, and randomized sums checked against an arithmetic reference.
module tb_neuron_accumulator;

  localparam int W_DATA  = 8;
  localparam int DATA_F  = 6;
  localparam int N_TERMS = 4;
  localparam int W_ACC   = 24;
  localparam int W_OUT   = 8;
  localparam int OUT_I   = 3;
  localparam int SHIFT   = 2 * DATA_F - (W_OUT - OUT_I);

  typedef logic [N_TERMS-1:0][W_DATA-1:0] terms_t;
  typedef struct packed {
    terms_t           xs;
    terms_t           ws;
    logic [W_OUT-1:0] expData;
    logic             expSat;
  } vec_t;

  logic              clock;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [W_DATA-1:0] in_x;
  logic [W_DATA-1:0] in_w;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  out_data;
  logic              out_sat;

  int compared   = 0;
  int mismatched = 0;

  neuron_accumulator #(
    .W_DATA (W_DATA),
    .DATA_F (DATA_F),
    .N_TERMS(N_TERMS),
    .W_ACC  (W_ACC),
    .W_OUT  (W_OUT),
    .OUT_I  (OUT_I)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Exact dot product, then round half up (floor of sum/2^S + 1/2) and clamp.
  function automatic void refModel(input terms_t xs, input terms_t ws,
                                   output logic [W_OUT-1:0] d, output logic s);
    longint total  = 0;
    longint divisor = longint'(1) <<< SHIFT;
    longint maxV   = (longint'(1) <<< (W_OUT - 1)) - 1;
    longint minV   = -maxV - 1;
    longint biased, q;
    for (int i = 0; i < N_TERMS; i++)
      total += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    biased = total + divisor / 2;
    q = biased / divisor;
    if ((biased % divisor != 0) && (biased < 0)) q = q - 1;
    if (q > maxV) begin
      d = maxV[W_OUT-1:0];
      s = 1'b1;
    end else if (q < minV) begin
      d = minV[W_OUT-1:0];
      s = 1'b1;
    end else begin
      d = q[W_OUT-1:0];
      s = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input string name, input terms_t xs, input terms_t ws,
                               input int gapMax, input int holdCycles,
                               input logic [W_OUT-1:0] expData, input logic expSat);
    int waitCnt;
    int gap;
    out_ready = (holdCycles == 0);
    for (int i = 0; i < N_TERMS; i++) begin
      gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_x = W_DATA'($urandom);
        in_w = W_DATA'($urandom);
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_x = xs[i];
      in_w = ws[i];
      waitCnt = 0;
      while (!in_ready && waitCnt < 20) begin
        @(posedge clock); #1;
        waitCnt++;
      end
      checkOutput({name, "/inReady"}, 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
    checkOutput({name, "/drainNoValid"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    checkOutput({name, "/latency"}, 32'(out_valid), 32'd1);
    checkOutput({name, "/data"}, 32'(out_data), 32'(expData));
    checkOutput({name, "/sat"}, 32'(out_sat), 32'(expSat));
    for (int h = 0; h < holdCycles; h++) begin
      in_valid = 1'b1;
      in_x = W_DATA'($urandom);
      in_w = W_DATA'($urandom);
      @(posedge clock); #1;
      checkOutput({name, "/holdValid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "/holdReady"}, 32'(in_ready), 32'd0);
      checkOutput({name, "/holdData"}, 32'(out_data), 32'(expData));
      checkOutput({name, "/holdSat"}, 32'(out_sat), 32'(expSat));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput({name, "/handoffValid"}, 32'(out_valid), 32'd0);
    checkOutput({name, "/handoffReady"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];
  terms_t rx, rw;
  logic [W_OUT-1:0] refData;
  logic refSat;

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    out_ready = 1'b0;

    // Term 0 sits in the low byte of each packed word.
    vecs[0] = '{xs: 32'h20202020, ws: 32'h20202020, expData: 8'h20, expSat: 1'b0};
    vecs[1] = '{xs: 32'h7F7F7F7F, ws: 32'h7F7F7F7F, expData: 8'h7F, expSat: 1'b1};
    vecs[2] = '{xs: 32'h80808080, ws: 32'h7F7F7F7F, expData: 8'h80, expSat: 1'b1};
    vecs[3] = '{xs: 32'h00000008, ws: 32'h00000008, expData: 8'h01, expSat: 1'b0};
    vecs[4] = '{xs: 32'h000000F8, ws: 32'h00000008, expData: 8'h00, expSat: 1'b0};
    vecs[5] = '{xs: 32'h3E404040, ws: 32'h40404040, expData: 8'h7F, expSat: 1'b0};
    vecs[6] = '{xs: 32'hC0C0C0C0, ws: 32'h40404040, expData: 8'h80, expSat: 1'b0};
    vecs[7] = '{xs: 32'h0130F010, ws: 32'h01081020, expData: 8'h05, expSat: 1'b0};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset/inReady", 32'(in_ready), 32'd1);
    checkOutput("reset/outValid", 32'(out_valid), 32'd0);
    checkOutput("reset/outData", 32'(out_data), 32'd0);
    checkOutput("reset/outSat", 32'(out_sat), 32'd0);
    resetn = 1'b1;
    checkOutput("release/inReady", 32'(in_ready), 32'd1);

    for (int k = 0; k < 8; k++)
      applyStimulus($sformatf("vec%0d", k), vecs[k].xs, vecs[k].ws, 0, 0,
                    vecs[k].expData, vecs[k].expSat);

    applyStimulus("hold", 32'h20202020, 32'h20202020, 0, 5, 8'h20, 1'b0);

    // Abort a sum halfway; none of its terms may leak into the next result.
    in_valid = 1'b1;
    in_x = 8'h7F;
    in_w = 8'h7F;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midReset/inReady", 32'(in_ready), 32'd1);
    checkOutput("midReset/outValid", 32'(out_valid), 32'd0);
    checkOutput("midReset/outData", 32'(out_data), 32'd0);
    checkOutput("midReset/outSat", 32'(out_sat), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    checkOutput("midReset/readyAfterRelease", 32'(in_ready), 32'd1);
    applyStimulus("afterReset", 32'h20202020, 32'h20202020, 0, 0, 8'h20, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N_TERMS; i++) begin
        rx[i] = W_DATA'($urandom);
        rw[i] = W_DATA'($urandom);
        if (n % 2 == 1) begin
          rx[i] = {{3{rx[i][4]}}, rx[i][4:0]};
          rw[i] = {{3{rw[i][4]}}, rw[i][4:0]};
        end
      end
      refModel(rx, rw, refData, refSat);
      applyStimulus($sformatf("rand%0d", n), rx, rw, 3, int'($urandom_range(2, 0)),
                    refData, refSat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
